// File: rtl/hpf_fir_mac_seq_if.sv
// hpf_fir_mac_seq_if: sample-in, coefficient-write and result-out signals of the FIR engine.
// The master side drives samples and coefficients; the slave side is the engine.
interface hpf_fir_mac_seq_if #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 8
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int AW    = $clog2(NTAPS);

    logic signed [DATA_W-1:0] _x_in;
    logic                     _x_valid_in;
    logic                     _x_ready_out;
    logic                     _coef_we_in;
    logic        [AW-1:0]     _coef_addr_in;
    logic signed [COEF_W-1:0] _coef_data_in;
    logic signed [ACC_W-1:0]  _y_out;
    logic                     _y_valid_out;
    logic                     _y_ready_in;

    modport master (
        output _x_in, _x_valid_in, _coef_we_in, _coef_addr_in, _coef_data_in, _y_ready_in,
        input  _x_ready_out, _y_out, _y_valid_out
    );

    modport slave (
        input  _x_in, _x_valid_in, _coef_we_in, _coef_addr_in, _coef_data_in, _y_ready_in,
        output _x_ready_out, _y_out, _y_valid_out
    );
endinterface

// File: rtl/hpf_fir_mac_seq.sv
// hpf_fir_mac_seq: sequential single-multiplier FIR engine with a carry-lookahead accumulator.
// One sample per handshake, NTAPS MAC cycles, then the result is held until taken.
module cla #(
    parameter int BITS = 32
) (
    input  logic [BITS-1:0] _a_in,
    input  logic [BITS-1:0] _b_in,
    input  logic            _c_in,
    output logic [BITS-1:0] _s_out,
    output logic            _c_out
);
    logic [BITS-1:0] g, p;
    logic [BITS:0]   c;

    assign g = _a_in & _b_in;
    assign p = _a_in ^ _b_in;

    always_comb begin
        c[0] = _c_in;
        for (int i = 0; i < BITS; i++) c[i+1] = g[i] | (p[i] & c[i]);
    end

    assign _s_out = p ^ c[BITS-1:0];
    assign _c_out = c[BITS];
endmodule

module hpf_fir_mac_seq #(
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int NTAPS  = 8
) (
    input logic                  _clk_in,
    input logic                  _rst_n_in,
    hpf_fir_mac_seq_if.slave     bus
);
    localparam int ACC_W = DATA_W + COEF_W + $clog2(NTAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int IW    = $clog2(NTAPS);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MAC  = 2'd1;
    localparam logic [1:0] OUT  = 2'd2;

    logic        [1:0]        state_q, state_d;
    logic        [IW-1:0]     idx_q, idx_d;
    logic        [ACC_W-1:0]  acc_q, acc_d;
    logic        [ACC_W-1:0]  y_q, y_d;
    logic signed [DATA_W-1:0] d_q [NTAPS];
    logic signed [DATA_W-1:0] d_d [NTAPS];
    logic signed [COEF_W-1:0] c_q [NTAPS];
    logic signed [COEF_W-1:0] c_d [NTAPS];

    logic signed [PW-1:0]     prod;
    logic        [ACC_W-1:0]  addend, sum;
    logic                     c_out_unused;
    logic                     coef_ok, accept, last;

    assign prod   = PW'(d_q[idx_q]) * PW'(c_q[idx_q]);
    assign addend = {{(ACC_W-PW){prod[PW-1]}}, prod};

    cla #(.BITS(ACC_W)) u_acc_add (
        ._a_in  (acc_q),
        ._b_in  (addend),
        ._c_in  (1'b0),
        ._s_out (sum),
        ._c_out (c_out_unused)
    );

    // Coefficients may only change between computations, so a result never mixes two sets.
    assign coef_ok = (state_q == IDLE) && bus._coef_we_in && (int'(bus._coef_addr_in) < NTAPS);
    assign accept  = (state_q == IDLE) && bus._x_valid_in;
    assign last    = idx_q == IW'(NTAPS - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        y_d     = y_q;
        d_d     = d_q;
        c_d     = c_q;
        if (coef_ok) c_d[bus._coef_addr_in] = bus._coef_data_in;
        if (accept) begin
            d_d[0] = bus._x_in;
            for (int k = 1; k < NTAPS; k++) d_d[k] = d_q[k-1];
            acc_d   = '0;
            idx_d   = '0;
            state_d = MAC;
        end
        if (state_q == MAC) begin
            acc_d = sum;
            idx_d = idx_q + IW'(1);
            if (last) begin
                y_d     = sum;
                state_d = OUT;
            end
        end
        if (state_q == OUT && bus._y_ready_in) state_d = IDLE;
    end

    always_ff @(posedge _clk_in or negedge _rst_n_in) begin
        if (!_rst_n_in) begin
            state_q <= IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            y_q     <= '0;
            d_q     <= '{default: '0};
            c_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            y_q     <= y_d;
            d_q     <= d_d;
            c_q     <= c_d;
        end
    end

    assign bus._x_ready_out = state_q == IDLE;
    assign bus._y_valid_out = state_q == OUT;
    assign bus._y_out       = y_q;
endmodule

// File: tb/tb_hpf_fir_mac_seq.sv
// tb_hpf_fir_mac_seq: directed checks of the FIR engine with NTAPS=4, 16-bit data and coefficients.
module tb_hpf_fir_mac_seq;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    hpf_fir_mac_seq_if #(.DATA_W(16), .COEF_W(16), .NTAPS(4)) bus ();

    hpf_fir_mac_seq #(.DATA_W(16), .COEF_W(16), .NTAPS(4)) dut (
        ._clk_in   (clk),
        ._rst_n_in (rst_n),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic load4(input int c0, input int c1, input int c2, input int c3);
        int cv [4];
        cv = '{c0, c1, c2, c3};
        for (int k = 0; k < 4; k++) begin
            bus._coef_we_in   = 1'b1;
            bus._coef_addr_in = 2'(k);
            bus._coef_data_in = 16'(cv[k]);
            @(negedge clk);
        end
        bus._coef_we_in = 1'b0;
    endtask

    // wr_at: -1 no write, 0 write c[0]=9 on the accept edge, 1 write c[0]=9 during the first MAC edge.
    // Leaves the engine in OUT with the result held.
    task automatic send(input longint x, input longint ey, input int wr_at, input string tag);
        int lat;
        bus._x_in         = 16'(x);
        bus._x_valid_in   = 1'b1;
        bus._coef_addr_in = 2'd0;
        bus._coef_data_in = 16'sd9;
        bus._coef_we_in   = wr_at == 0;
        @(negedge clk);
        bus._x_valid_in = 1'b0;
        lat = 0;
        while (!bus._y_valid_out && lat < 20) begin
            bus._coef_we_in = (lat == 0) && (wr_at == 1);
            @(negedge clk);
            lat++;
        end
        bus._coef_we_in = 1'b0;
        chk({tag, "_lat"}, lat, 4);
        chk({tag, "_y"}, bus._y_out, ey);
    endtask

    task automatic take();
        bus._y_ready_in = 1'b1;
        @(negedge clk);
        bus._y_ready_in = 1'b0;
    endtask

    initial begin
        longint imp_x [5];
        longint imp_y [5];
        longint big;
        int lat;
        bus._x_in = '0;
        bus._x_valid_in = 1'b0;
        bus._coef_we_in = 1'b0;
        bus._coef_addr_in = '0;
        bus._coef_data_in = '0;
        bus._y_ready_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ready", bus._x_ready_out, 1);
        chk("rst_valid", bus._y_valid_out, 0);
        chk("rst_y", bus._y_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        load4(1, -1, 0, 0);
        send(5, 5, -1, "t1a");
        take();
        send(5, 0, -1, "t1b");
        take();
        send(2, -3, -1, "t1c");
        take();

        do_reset();
        load4(3, -2, 7, -1);
        imp_x = '{1, 0, 0, 0, 0};
        imp_y = '{3, -2, 7, -1, 0};
        for (int i = 0; i < 5; i++) begin
            send(imp_x[i], imp_y[i], -1, $sformatf("t2_%0d", i));
            take();
        end

        do_reset();
        load4(1, 2, 0, 0);
        send(3, 3, -1, "t3a");
        bus._x_in = 16'sd5;
        bus._x_valid_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_valid", bus._y_valid_out, 1);
            chk("t3_y", bus._y_out, 3);
            chk("t3_ready", bus._x_ready_out, 0);
        end
        bus._y_ready_in = 1'b1;
        @(negedge clk);
        bus._y_ready_in = 1'b0;
        chk("t3_idle_ready", bus._x_ready_out, 1);
        @(negedge clk);
        bus._x_valid_in = 1'b0;
        lat = 0;
        while (!bus._y_valid_out && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("t3b_lat", lat, 4);
        chk("t3b_y", bus._y_out, 11);
        take();

        do_reset();
        load4(-32768, -32768, -32768, -32768);
        big = longint'(1) << 30;
        for (int i = 1; i <= 4; i++) begin
            send(-32768, big * i, -1, $sformatf("t4_%0d", i));
            take();
        end

        load4(1, 1, 1, 1);
        bus._x_in = 16'sd7;
        bus._x_valid_in = 1'b1;
        @(negedge clk);
        bus._x_valid_in = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("t5_valid", bus._y_valid_out, 0);
        chk("t5_ready", bus._x_ready_out, 1);
        chk("t5_y", bus._y_out, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t5_novalid", bus._y_valid_out, 0);
        end
        load4(1, 1, 1, 1);
        send(4, 4, -1, "t5b");
        take();

        do_reset();
        load4(2, 1, 0, 0);
        send(3, 6, 1, "t6a");
        take();
        send(1, 5, -1, "t6b");
        take();
        send(1, 10, 0, "t6c");
        take();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
